// File: rtl/fp_sched_pkg.sv
// Shared types and constants for the fp operation scheduler.
package fp_sched_pkg;

    typedef enum logic [1:0] {
        OpAdd     = 2'd0,
        OpSub     = 2'd1,
        OpMul     = 2'd2,
        OpIllegal = 2'd3
    } fp_op_e;

    typedef enum logic {
        StRun,
        StDrain
    } sched_state_e;

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    localparam int unsigned DEFAULT_DEPTH = 4;
    localparam int unsigned DEFAULT_TAG_W = 4;

endpackage

// File: rtl/fp_op_scheduler_if.sv
// Command, unit and response buses of the fp operation scheduler.
interface fp_op_scheduler_if #(
    parameter int unsigned TAG_W = fp_sched_pkg::DEFAULT_TAG_W
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [31:0]      cmd_a;
    logic [31:0]      cmd_b;
    logic [TAG_W-1:0] cmd_tag;

    logic [2:0]       unit_in_valid;
    logic [2:0]       unit_in_ready;
    logic [31:0]      unit_a;
    logic [31:0]      unit_b;
    logic [95:0]      unit_z;
    logic [2:0]       unit_z_valid;
    logic [2:0]       unit_z_ready;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [31:0]      rsp_z;
    logic [TAG_W-1:0] rsp_tag;
    logic             rsp_err;

    // Scheduler side.
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        output cmd_ready,
        output unit_in_valid, unit_a, unit_b, unit_z_ready,
        input  unit_in_ready, unit_z, unit_z_valid,
        output rsp_valid, rsp_z, rsp_tag, rsp_err,
        input  rsp_ready
    );

    // Requester and arithmetic-unit side.
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, cmd_tag,
        input  cmd_ready,
        input  unit_in_valid, unit_a, unit_b, unit_z_ready,
        output unit_in_ready, unit_z, unit_z_valid,
        input  rsp_valid, rsp_z, rsp_tag, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/fp_sched_order_fifo.sv
// Order FIFO of accepted {op, tag}; pointers carry an extra wrap bit.
module fp_sched_order_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 6,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty,
    output logic [PTR_W:0]   count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W:0]   wr_ptr_q, rd_ptr_q;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end

    assign rdata = mem[rd_ptr_q[PTR_W-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign count = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/fp_op_scheduler.sv
// Dispatches fp commands to add/sub/mul units and returns results in acceptance order.
module fp_op_scheduler
    import fp_sched_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned TAG_W = DEFAULT_TAG_W,
    localparam int unsigned OUT_W = $clog2(DEPTH + 2)
) (
    input  logic             clk,
    input  logic             nreset,
    fp_op_scheduler_if.slave bus,
    input  logic             flush_req,
    output logic             flush_done,
    output logic [OUT_W-1:0] outstanding
);

    localparam int unsigned ENTRY_W = 2 + TAG_W;

    sched_state_e     state_q, state_d;
    logic             run;
    logic             fifo_full, fifo_empty, push, load_en;
    logic [ENTRY_W-1:0] head;
    logic [1:0]       head_op;
    logic [TAG_W-1:0] head_tag;
    logic [OUT_W-1:0] fifo_count;
    logic [3:0]       in_ready_ext, z_valid_ext, in_valid_sel, z_ready_sel;

    logic             rsp_valid_q, rsp_valid_d;
    logic [31:0]      rsp_z_q, rsp_z_d;
    logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
    logic             rsp_err_q, rsp_err_d;

    assign run         = (state_q == StRun);
    assign bus.unit_a  = bus.cmd_a;
    assign bus.unit_b  = bus.cmd_b;

    // The illegal opcode has no unit; a constant-1 slot lets it share the indexed paths.
    assign in_ready_ext = {1'b1, bus.unit_in_ready};
    assign z_valid_ext  = {1'b1, bus.unit_z_valid};

    always_comb begin
        in_valid_sel = '0;
        in_valid_sel[bus.cmd_op] = bus.cmd_valid & ~fifo_full & run;
    end
    assign bus.unit_in_valid = in_valid_sel[2:0];

    assign bus.cmd_ready = run & ~fifo_full & in_ready_ext[bus.cmd_op];
    assign push          = bus.cmd_valid & bus.cmd_ready;

    fp_sched_order_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_order_fifo (
        .clk    (clk),
        .nreset (nreset),
        .push   (push),
        .wdata  ({bus.cmd_op, bus.cmd_tag}),
        .pop    (load_en),
        .rdata  (head),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (fifo_count)
    );

    assign head_op  = head[ENTRY_W-1 -: 2];
    assign head_tag = head[TAG_W-1:0];
    assign load_en  = ~fifo_empty & (~rsp_valid_q | bus.rsp_ready) & z_valid_ext[head_op];

    always_comb begin
        z_ready_sel = '0;
        z_ready_sel[head_op] = load_en;
    end
    assign bus.unit_z_ready = z_ready_sel[2:0];

    always_comb begin
        rsp_valid_d = rsp_valid_q;
        rsp_z_d     = rsp_z_q;
        rsp_tag_d   = rsp_tag_q;
        rsp_err_d   = rsp_err_q;
        if (load_en) begin
            rsp_valid_d = 1'b1;
            rsp_tag_d   = head_tag;
            rsp_err_d   = 1'b0;
            unique case (fp_op_e'(head_op))
                OpAdd: rsp_z_d = bus.unit_z[31:0];
                OpSub: rsp_z_d = bus.unit_z[63:32];
                OpMul: rsp_z_d = bus.unit_z[95:64];
                OpIllegal: begin
                    rsp_z_d   = QNAN;
                    rsp_err_d = 1'b1;
                end
            endcase
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        unique case (state_q)
            StRun: if (flush_req) state_d = StDrain;
            StDrain: begin
                if (fifo_empty && !rsp_valid_q) begin
                    state_d    = StRun;
                    flush_done = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= StRun;
            rsp_valid_q <= 1'b0;
            rsp_z_q     <= '0;
            rsp_tag_q   <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_z_q     <= rsp_z_d;
            rsp_tag_q   <= rsp_tag_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_z     = rsp_z_q;
    assign bus.rsp_tag   = rsp_tag_q;
    assign bus.rsp_err   = rsp_err_q;
    assign outstanding   = fifo_count + OUT_W'(rsp_valid_q);

endmodule
